// File: rtl/multdiv_unit_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package multdiv_unit_pkg;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;
  localparam int CW      = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_unit_addsub33.sv
// 33-bit ripple add/subtract built from gate-level full-adder slices.
// With sub=1 the b operand is inverted and the carry-in is forced to one.
module addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  logic [32:0] bx;
  logic [32:0] carry;

  assign carry[0] = sub;

  for (genvar i = 0; i < 33; i++) begin : g_slice
    assign bx[i]  = b[i] ^ sub;
    assign sum[i] = a[i] ^ bx[i] ^ carry[i];
  end

  for (genvar i = 0; i < 32; i++) begin : g_carry
    assign carry[i+1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit, one bit per clock.
// acc/lo form a 65-bit shift pair: product high/low for multiply,
// remainder/dividend-quotient for divide. One shared add/sub does both.
module multdiv_unit
  import multdiv_unit_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_t          state;
  logic [CW-1:0]   count;
  logic [32:0]     acc;
  logic [31:0]     lo;
  logic [32:0]     operand;
  logic            isDiv;
  logic            negQ;
  logic            divZero;
  logic            divOvf;

  logic            start;
  logic            lastStep;
  logic [31:0]     absA;
  logic [31:0]     absB;
  logic [32:0]     asA;
  logic            asSub;
  logic [32:0]     asSum;
  logic [32:0]     mulSum;
  logic [63:0]     product;
  logic [32:0]     prodHigh;
  logic [31:0]     finalRes;
  logic            finalExc;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign lastStep = (count == CW'(WIDTH - 1));
  assign absA     = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign absB     = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
  assign mulSum   = lo[0] ? asSum : acc;
  assign product  = {acc[31:0], lo};
  assign prodHigh = product[63:31];

  addsub33 u_addsub (
    .a   (acc_sel_a()),
    .b   (operand),
    .sub (asSub),
    .sum (asSum)
  );

  function automatic logic [32:0] acc_sel_a();
    return asA;
  endfunction

  // Adder input select: accumulate (subtract on the sign step) or trial subtract.
  always_comb begin
    asA   = acc;
    asSub = lastStep;
    if (state == DIV) begin
      asA   = {acc[31:0], lo[31]};
      asSub = 1'b1;
    end
  end

  // Final result and exception computed from the iteration registers.
  always_comb begin
    finalRes = product[31:0];
    finalExc = !((&prodHigh) | (~|prodHigh));
    if (isDiv) begin
      if (divZero) begin
        finalRes = '0;
        finalExc = 1'b1;
      end else begin
        finalRes = negQ ? (~lo + 32'd1) : lo;
        finalExc = divOvf;
      end
    end
  end

  // Control FSM and datapath: start anywhere restarts, DONE registers outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      lo             <= '0;
      operand        <= '0;
      isDiv          <= 1'b0;
      negQ           <= 1'b0;
      divZero        <= 1'b0;
      divOvf         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        count <= '0;
        acc   <= '0;
        isDiv <= !ctrl_MULT;
        if (ctrl_MULT) begin
          state   <= MULT;
          operand <= {data_operandA[31], data_operandA};
          lo      <= data_operandB;
        end else begin
          state   <= DIV;
          operand <= {1'b0, absB};
          lo      <= absA;
          negQ    <= data_operandA[31] ^ data_operandB[31];
          divZero <= (data_operandB == '0);
          divOvf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
        end
      end else begin
        case (state)
          MULT: begin
            acc   <= {mulSum[32], mulSum[32:1]};
            lo    <= {mulSum[0], lo[31:1]};
            count <= count + CW'(1);
            if (lastStep) state <= DONE;
          end
          DIV: begin
            if (!asSum[32]) begin
              acc <= asSum;
              lo  <= {lo[30:0], 1'b1};
            end else begin
              acc <= {acc[31:0], lo[31]};
              lo  <= {lo[30:0], 1'b0};
            end
            count <= count + CW'(1);
            if (lastStep) state <= DONE;
          end
          DONE: begin
            data_result    <= finalRes;
            data_exception <= finalExc;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_multdiv_unit;

  localparam int EXP_LAT = 33;
  localparam int WATCH   = EXP_LAT + 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        mulGo;
  logic        divGo;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int testCount = 0;
  int failCount = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .ctrl_MULT      (mulGo),
    .ctrl_DIV       (divGo),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: signed 64-bit product / truncating signed quotient.
  task automatic refModel(input logic isMul, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e);
    int     sa;
    int     sb;
    longint p;
    sa = a;
    sb = b;
    if (isMul) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = sa / sb;
      e = 1'b0;
    end
  endtask

  // Drive a one-cycle start pulse; returns just after the sampling edge.
  task automatic applyStimulus(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opA   = a;
    opB   = b;
    mulGo = mul;
    divGo = div;
    @(posedge clock);
    #1;
    mulGo = 1'b0;
    divGo = 1'b0;
    opA   = $urandom;
    opB   = $urandom;
  endtask

  // Watch a bounded number of edges, recording RDY pulses and the first result.
  task automatic watchResult(input int edges, output int firstEdge, output int pulses,
                             output logic [31:0] res, output logic exc);
    firstEdge = -1;
    pulses    = 0;
    res       = '0;
    exc       = 1'b0;
    for (int i = 1; i <= edges; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        pulses++;
        if (firstEdge < 0) begin
          firstEdge = i;
          res       = data_result;
          exc       = data_exception;
        end
      end
    end
  endtask

  task automatic checkTransaction(input string tag, input logic [31:0] er, input logic ee);
    int          fe;
    int          p;
    logic [31:0] res;
    logic        exc;
    watchResult(WATCH, fe, p, res, exc);
    checkOutput({tag, " latency"}, 32'(fe), 32'(EXP_LAT));
    checkOutput({tag, " pulses"}, 32'(p), 32'd1);
    checkOutput({tag, " result"}, res, er);
    checkOutput({tag, " exception"}, {31'd0, exc}, {31'd0, ee});
    checkOutput({tag, " held result"}, data_result, er);
    checkOutput({tag, " held exception"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  task automatic runOp(input string tag, input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    refModel(mul, a, b, er, ee);
    applyStimulus(mul, div, a, b);
    checkTransaction(tag, er, ee);
  endtask

  task automatic checkQuietAndCleared(input string tag);
    int          fe;
    int          p;
    logic [31:0] res;
    logic        exc;
    watchResult(WATCH + 4, fe, p, res, exc);
    checkOutput({tag, " no rdy"}, 32'(p), 32'd0);
    checkOutput({tag, " result zero"}, data_result, 32'd0);
    checkOutput({tag, " exception zero"}, {31'd0, data_exception}, 32'd0);
  endtask

  initial begin
    int          fe;
    int          p;
    logic [31:0] res;
    logic        exc;
    logic [31:0] a;
    logic [31:0] b;
    logic        mul;

    reset = 1'b1;
    mulGo = 1'b0;
    divGo = 1'b0;
    opA   = '0;
    opB   = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset result", data_result, 32'd0);
    checkOutput("reset exception", {31'd0, data_exception}, 32'd0);
    checkOutput("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    runOp("mul 7x-6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    runOp("mul ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    runOp("mul min fits", 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_8000);
    runOp("div -100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    runOp("div 100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    runOp("div 3/5", 1'b0, 1'b1, 32'd3, 32'd5);
    runOp("div 5/0", 1'b0, 1'b1, 32'd5, 32'd0);
    runOp("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("div min/3", 1'b0, 1'b1, 32'h8000_0000, 32'd3);

    // Restart: DIV at edge 10 of a MULT abandons the multiply.
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
    watchResult(9, fe, p, res, exc);
    checkOutput("restart quiet", 32'(p), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd20, 32'd3);
    checkTransaction("restart div", 32'd6, 1'b0);

    runOp("both pulses", 1'b1, 1'b1, 32'd6, 32'd2);

    // Reset sampled at edge 15 of a multiply.
    applyStimulus(1'b1, 1'b0, 32'd1234, 32'd5678);
    watchResult(14, fe, p, res, exc);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkQuietAndCleared("reset mid-op");

    // Reset coincident with a start pulse.
    runOp("pre coincident", 1'b1, 1'b0, 32'd6, 32'd2);
    @(negedge clock);
    reset = 1'b1;
    mulGo = 1'b1;
    opA   = 32'd6;
    opB   = 32'd2;
    @(negedge clock);
    reset = 1'b0;
    mulGo = 1'b0;
    checkQuietAndCleared("reset with start");

    for (int i = 0; i < 30; i++) begin
      mul = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 40) - 20;
        1: begin a = $urandom_range(0, 70000) - 35000; b = $urandom_range(0, 70000) - 35000; end
        default: ;
      endcase
      runOp(mul ? "rand mul" : "rand div", mul, !mul, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
